// File: rtl/uart_rx_deframer_pkg.sv
// Shared definitions for the UART receive deframer: FSM states and default timing.
package uart_rx_deframer_pkg;

  localparam int unsigned DefClkDiv     = 27;  // 50 MHz / (115200 * 16)
  localparam int unsigned DefOversample = 16;
  localparam int unsigned DefDataBits   = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } rx_state_e;

endpackage

// File: rtl/uart_rx_deframer_if.sv
// Received-byte handshake plus status flags between the deframer and its consumer.
interface uart_rx_deframer_if #(
  parameter int unsigned DATA_BITS = 8
);

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  // Deframer side
  modport master (
    output rx_data, rx_valid, frame_err, overrun, busy,
    input  rx_ready
  );

  // Consumer side
  modport slave (
    input  rx_data, rx_valid, frame_err, overrun, busy,
    output rx_ready
  );

endinterface

// File: rtl/uart_rx_deframer_baud_tick.sv
// Oversample tick generator: counts 0..CLK_DIV-1 and ticks on the last count.
// A synchronous clear restarts the count so ticks can be phase-aligned to an edge.
module uart_rx_deframer_baud_tick
  import uart_rx_deframer_pkg::*;
#(
  parameter int unsigned CLK_DIV = DefClkDiv
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CntW-1:0] r_cnt;
  logic            w_wrap;

  assign w_wrap = (r_cnt == CntW'(CLK_DIV - 1));
  // A clear wins over a coincident wrap so no stale tick leaks into a new frame.
  assign o_tick = w_wrap & ~i_clr;

  // Divider counter with synchronous clear
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive front end: synchronises rxd, oversamples it, deframes 8N1 characters
// (LSB first) and presents each byte on a valid/ready handshake with error pulses.
module uart_rx_deframer
  import uart_rx_deframer_pkg::*;
#(
  parameter int unsigned CLK_DIV    = DefClkDiv,
  parameter int unsigned OVERSAMPLE = DefOversample,
  parameter int unsigned DATA_BITS  = DefDataBits
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_rxd,
  uart_rx_deframer_if.master  rx_if
);

  localparam int unsigned OsW  = $clog2(OVERSAMPLE);
  localparam int unsigned BitW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  logic [1:0]           r_sync;
  logic                 w_rxd_s;
  logic                 w_tick;

  rx_state_e            r_state,  w_state_d;
  logic [OsW-1:0]       r_os_cnt, w_os_cnt_d;
  logic [BitW-1:0]      r_bit_cnt, w_bit_cnt_d;
  logic [DATA_BITS-1:0] r_shreg,  w_shreg_d;
  logic                 w_start_det;
  logic                 w_deliver;
  logic                 w_stop_bad;

  logic [DATA_BITS-1:0] r_rx_data,  w_rx_data_d;
  logic                 r_rx_valid, w_rx_valid_d;
  logic                 r_frame_err, w_frame_err_d;
  logic                 r_overrun,  w_overrun_d;

  assign w_rxd_s = r_sync[1];

  // Two-flop synchroniser; resets to the idle (high) line level
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_rxd};
    end
  end

  uart_rx_deframer_baud_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_start_det),
    .o_tick (w_tick)
  );

  // Deframing FSM next-state, sample counters and shift register
  always_comb begin
    w_state_d   = r_state;
    w_os_cnt_d  = r_os_cnt;
    w_bit_cnt_d = r_bit_cnt;
    w_shreg_d   = r_shreg;
    w_start_det = 1'b0;
    w_deliver   = 1'b0;
    w_stop_bad  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!w_rxd_s) begin
          w_start_det = 1'b1;
          w_state_d   = StStart;
          w_os_cnt_d  = '0;
          w_bit_cnt_d = '0;
        end
      end
      StStart: begin
        if (w_tick) begin
          if (r_os_cnt == OsW'(OVERSAMPLE / 2 - 1)) begin
            w_os_cnt_d = '0;
            // Line back high at mid start bit: treat as a glitch
            w_state_d  = w_rxd_s ? StIdle : StData;
          end else begin
            w_os_cnt_d = r_os_cnt + 1'b1;
          end
        end
      end
      StData: begin
        if (w_tick) begin
          if (r_os_cnt == OsW'(OVERSAMPLE - 1)) begin
            w_os_cnt_d = '0;
            w_shreg_d  = {w_rxd_s, r_shreg[DATA_BITS-1:1]};
            if (r_bit_cnt == BitW'(DATA_BITS - 1)) begin
              w_bit_cnt_d = '0;
              w_state_d   = StStop;
            end else begin
              w_bit_cnt_d = r_bit_cnt + 1'b1;
            end
          end else begin
            w_os_cnt_d = r_os_cnt + 1'b1;
          end
        end
      end
      StStop: begin
        if (w_tick) begin
          if (r_os_cnt == OsW'(OVERSAMPLE - 1)) begin
            w_os_cnt_d = '0;
            if (w_rxd_s) begin
              w_deliver = 1'b1;
              w_state_d = StIdle;
            end else begin
              w_stop_bad = 1'b1;
              w_state_d  = StBreak;
            end
          end else begin
            w_os_cnt_d = r_os_cnt + 1'b1;
          end
        end
      end
      StBreak: begin
        // Held-low line must return high before a new start can be seen
        if (w_rxd_s) begin
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // FSM state, counters and shift register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_os_cnt  <= '0;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
    end else begin
      r_state   <= w_state_d;
      r_os_cnt  <= w_os_cnt_d;
      r_bit_cnt <= w_bit_cnt_d;
      r_shreg   <= w_shreg_d;
    end
  end

  // Holding register: load, accept, overrun and frame-error pulses
  always_comb begin
    w_rx_data_d   = r_rx_data;
    w_rx_valid_d  = r_rx_valid;
    w_overrun_d   = 1'b0;
    w_frame_err_d = w_stop_bad;
    if (w_deliver) begin
      if (!r_rx_valid || rx_if.rx_ready) begin
        w_rx_data_d  = r_shreg;
        w_rx_valid_d = 1'b1;
      end else begin
        // Consumer still holds the previous byte: keep it, drop the new one
        w_overrun_d = 1'b1;
      end
    end else if (r_rx_valid && rx_if.rx_ready) begin
      w_rx_valid_d = 1'b0;
    end
  end

  // Output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_rx_data   <= w_rx_data_d;
      r_rx_valid  <= w_rx_valid_d;
      r_frame_err <= w_frame_err_d;
      r_overrun   <= w_overrun_d;
    end
  end

  assign rx_if.rx_data   = r_rx_data;
  assign rx_if.rx_valid  = r_rx_valid;
  assign rx_if.frame_err = r_frame_err;
  assign rx_if.overrun   = r_overrun;
  assign rx_if.busy      = (r_state != StIdle);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer at CLK_DIV=4, OVERSAMPLE=16 (64 clk per bit).
module tb_uart_rx_deframer;

  localparam int BitClk = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;

  int checks   = 0;
  int failures = 0;

  // Event counters maintained by the monitor
  int       n_rise      = 0;
  int       n_valid_cyc = 0;
  int       n_data_chg  = 0;
  int       n_ferr      = 0;
  int       n_ovr       = 0;
  int       n_both      = 0;
  int       n_busy      = 0;
  logic [7:0] last_data = 8'h00;
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  uart_rx_deframer_if #(.DATA_BITS(8)) rx_if ();

  uart_rx_deframer #(
    .CLK_DIV    (4),
    .OVERSAMPLE (16),
    .DATA_BITS  (8)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_rxd (rxd),
    .rx_if (rx_if)
  );

  always #5 clk = ~clk;

  // Monitor samples on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (rx_if.rx_valid && !prev_valid) begin
      n_rise    <= n_rise + 1;
      last_data <= rx_if.rx_data;
    end
    if (rx_if.rx_valid && prev_valid && (rx_if.rx_data != prev_data)) n_data_chg <= n_data_chg + 1;
    if (rx_if.rx_valid)                    n_valid_cyc <= n_valid_cyc + 1;
    if (rx_if.frame_err)                   n_ferr <= n_ferr + 1;
    if (rx_if.overrun)                     n_ovr  <= n_ovr + 1;
    if (rx_if.frame_err && rx_if.overrun)  n_both <= n_both + 1;
    if (rx_if.busy)                        n_busy <= n_busy + 1;
    prev_valid <= rx_if.rx_valid;
    prev_data  <= rx_if.rx_data;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rxd = 1'b0;
    idle(BitClk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      idle(BitClk);
    end
    rxd = stop;
    idle(BitClk);
    rxd = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rxd = 1'b1;
    rx_if.rx_ready = 1'b0;
    idle(3);
    checks++;
    if (rx_if.rx_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%b exp=0", rx_if.rx_valid);
    end
    checks++;
    if (rx_if.rx_data !== 8'h00) begin
      failures++; $display("FAIL reset_data got=%h exp=00", rx_if.rx_data);
    end
    checks++;
    if ({rx_if.frame_err, rx_if.overrun, rx_if.busy} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b exp=000",
                           {rx_if.frame_err, rx_if.overrun, rx_if.busy});
    end
    rst = 1'b0;
    idle(20);
    checks++;
    if (rx_if.busy !== 1'b0) begin
      failures++; $display("FAIL reset_idle_busy got=%b exp=0", rx_if.busy);
    end
  endtask

  task automatic test_basic();
    int r0, v0, f0, o0;
    rx_if.rx_ready = 1'b1;
    r0 = n_rise; v0 = n_valid_cyc; f0 = n_ferr; o0 = n_ovr;
    send_frame(8'h55, 1'b1);
    idle(40);
    checks++;
    if (n_rise - r0 != 1) begin
      failures++; $display("FAIL basic_rise got=%0d exp=1", n_rise - r0);
    end
    checks++;
    if (n_valid_cyc - v0 != 1) begin
      failures++; $display("FAIL basic_valid_cycles got=%0d exp=1", n_valid_cyc - v0);
    end
    checks++;
    if (last_data !== 8'h55) begin
      failures++; $display("FAIL basic_data got=%h exp=55", last_data);
    end
    checks++;
    if ((n_ferr - f0) + (n_ovr - o0) != 0) begin
      failures++; $display("FAIL basic_flags got=%0d exp=0", (n_ferr - f0) + (n_ovr - o0));
    end
    checks++;
    if (rx_if.busy !== 1'b0) begin
      failures++; $display("FAIL basic_busy_after got=%b exp=0", rx_if.busy);
    end
  endtask

  task automatic test_hold();
    int c0;
    rx_if.rx_ready = 1'b0;
    c0 = n_data_chg;
    send_frame(8'hA3, 1'b1);
    idle(500);
    checks++;
    if (rx_if.rx_valid !== 1'b1) begin
      failures++; $display("FAIL hold_valid got=%b exp=1", rx_if.rx_valid);
    end
    checks++;
    if (rx_if.rx_data !== 8'hA3) begin
      failures++; $display("FAIL hold_data got=%h exp=a3", rx_if.rx_data);
    end
    checks++;
    if (n_data_chg != c0) begin
      failures++; $display("FAIL hold_stable got=%0d changes exp=0", n_data_chg - c0);
    end
    rx_if.rx_ready = 1'b1;
    @(negedge clk);
    rx_if.rx_ready = 1'b0;
    checks++;
    if (rx_if.rx_valid !== 1'b0) begin
      failures++; $display("FAIL hold_accept got=%b exp=0", rx_if.rx_valid);
    end
  endtask

  task automatic test_overrun();
    int r0, o0, f0;
    rx_if.rx_ready = 1'b0;
    r0 = n_rise; o0 = n_ovr; f0 = n_ferr;
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    idle(40);
    checks++;
    if (n_ovr - o0 != 1) begin
      failures++; $display("FAIL overrun_pulse got=%0d exp=1", n_ovr - o0);
    end
    checks++;
    if (rx_if.rx_data !== 8'h12) begin
      failures++; $display("FAIL overrun_data got=%h exp=12", rx_if.rx_data);
    end
    checks++;
    if (n_rise - r0 != 1 || rx_if.rx_valid !== 1'b1) begin
      failures++; $display("FAIL overrun_valid got=%0d rises,valid=%b exp=1 rise,valid=1",
                           n_rise - r0, rx_if.rx_valid);
    end
    checks++;
    if (n_ferr != f0) begin
      failures++; $display("FAIL overrun_no_ferr got=%0d exp=0", n_ferr - f0);
    end
    rx_if.rx_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rx_if.rx_valid !== 1'b0) begin
      failures++; $display("FAIL overrun_accept got=%b exp=0", rx_if.rx_valid);
    end
  endtask

  task automatic test_frame_err();
    int r0, f0, o0, b0;
    rx_if.rx_ready = 1'b1;
    r0 = n_rise; f0 = n_ferr; o0 = n_ovr; b0 = n_both;
    send_frame(8'h7E, 1'b0);
    idle(100);
    checks++;
    if (n_ferr - f0 != 1) begin
      failures++; $display("FAIL ferr_pulse got=%0d exp=1", n_ferr - f0);
    end
    checks++;
    if (n_rise != r0 || n_ovr != o0 || n_both != b0) begin
      failures++; $display("FAIL ferr_no_valid got=%0d rises,%0d ovr exp=0,0",
                           n_rise - r0, n_ovr - o0);
    end
    send_frame(8'h81, 1'b1);
    idle(40);
    checks++;
    if (n_rise - r0 != 1 || last_data !== 8'h81) begin
      failures++; $display("FAIL ferr_recover got=%0d rises,data=%h exp=1,81",
                           n_rise - r0, last_data);
    end
  endtask

  task automatic test_glitch();
    int r0, f0, o0, b0;
    r0 = n_rise; f0 = n_ferr; o0 = n_ovr; b0 = n_busy;
    @(negedge clk);
    rxd = 1'b0;
    idle(20);
    rxd = 1'b1;
    idle(100);
    checks++;
    if (n_busy == b0) begin
      failures++; $display("FAIL glitch_start got=0 busy cycles exp>0");
    end
    checks++;
    if (rx_if.busy !== 1'b0) begin
      failures++; $display("FAIL glitch_idle got=%b exp=0", rx_if.busy);
    end
    checks++;
    if (n_rise != r0 || n_ferr != f0 || n_ovr != o0) begin
      failures++; $display("FAIL glitch_flags got=%0d/%0d/%0d exp=0/0/0",
                           n_rise - r0, n_ferr - f0, n_ovr - o0);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] b;
    int r0;
    rx_if.rx_ready = 1'b1;
    b = 8'hC3;
    @(negedge clk);
    rxd = 1'b0;
    idle(BitClk);
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      idle(BitClk);
    end
    rxd = b[4];
    idle(BitClk / 2);
    checks++;
    if (rx_if.busy !== 1'b1) begin
      failures++; $display("FAIL midrst_busy_before got=%b exp=1", rx_if.busy);
    end
    rst = 1'b1;
    rxd = 1'b1;
    @(negedge clk);
    checks++;
    if ({rx_if.busy, rx_if.rx_valid, rx_if.frame_err, rx_if.overrun} !== 4'b0000 ||
        rx_if.rx_data !== 8'h00) begin
      failures++; $display("FAIL midrst_outputs got=%b data=%h exp=0000 data=00",
                           {rx_if.busy, rx_if.rx_valid, rx_if.frame_err, rx_if.overrun},
                           rx_if.rx_data);
    end
    rst = 1'b0;
    idle(100);
    r0 = n_rise;
    send_frame(8'h3C, 1'b1);
    idle(40);
    checks++;
    if (n_rise - r0 != 1 || last_data !== 8'h3C) begin
      failures++; $display("FAIL midrst_next got=%0d rises,data=%h exp=1,3c",
                           n_rise - r0, last_data);
    end
  endtask

  initial begin
    rx_if.rx_ready = 1'b0;
    test_reset();
    test_basic();
    test_hold();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_mid_reset();
    checks++;
    if (n_both != 0) begin
      failures++; $display("FAIL flags_exclusive got=%0d exp=0", n_both);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
